// File: rtl/accum_adder.sv
// Purpose : registered add/sub/accumulate unit with per-result carry/borrow and sticky carry/overflow latches.
// Latency : 1 cycle from accept (in_valid && in_ready) to sum/carry with out_valid.
// Backpr. : single-entry output register; in_ready = !clear && (!out_valid || out_ready), result held while stalled.
//
// Ports:
//   iCE_CLK, reset_n        clock, asynchronous active-low reset
//   clear                   synchronous clear of accumulator, latches and output register
//   in_valid/in_ready       operation handshake; in_a, in_b operands; mode 00 A+B, 01 A-B, 10 ACC+A, 11 ACC-A
//   out_valid/out_ready     result handshake; sum, carry are the registered result
//   carry_latch             sticky carry/borrow since clear/reset
//   overflow_latch          sticky signed overflow since clear/reset
module accum_adder #(
   parameter int WIDTH    = 8,
   parameter bit SATURATE = 1'b0
) (
   input  logic             iCE_CLK,
   input  logic             reset_n,
   input  logic             clear,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [1:0]       mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             carry,
   output logic             carry_latch,
   output logic             overflow_latch
);

   logic [WIDTH-1:0] r_acc;
   logic [WIDTH-1:0] r_sum;
   logic             r_carry;
   logic             r_out_valid;
   logic             r_carry_latch;
   logic             r_ovf_latch;

   logic             w_sub;
   logic             w_accept;
   logic [WIDTH-1:0] w_x;
   logic [WIDTH-1:0] w_y;
   logic [WIDTH-1:0] w_y_eff;
   logic [WIDTH:0]   w_raw;
   logic             w_cy;
   logic             w_ovf;
   logic [WIDTH-1:0] w_res;

   // reset_n gates in_ready so nothing is offered as acceptable while in reset.
   assign in_ready = reset_n && !clear && (!r_out_valid || out_ready);
   assign w_accept = in_valid && in_ready;

   always_comb begin
      w_sub   = mode[0];
      w_x     = mode[1] ? r_acc : in_a;
      w_y     = mode[1] ? in_a  : in_b;
      // Subtraction as X + ~Y + 1 so one adder serves both operations.
      w_y_eff = w_sub ? ~w_y : w_y;
      w_raw   = {1'b0, w_x} + {1'b0, w_y_eff} + {{WIDTH{1'b0}}, w_sub};
      // Carry-out of X + ~Y + 1 is the inverse of borrow.
      w_cy    = w_raw[WIDTH] ^ w_sub;
      w_ovf   = (w_x[WIDTH-1] == w_y_eff[WIDTH-1]) && (w_raw[WIDTH-1] != w_x[WIDTH-1]);
      w_res   = w_raw[WIDTH-1:0];
      if (SATURATE && w_cy) begin
         w_res = w_sub ? {WIDTH{1'b0}} : {WIDTH{1'b1}};
      end
   end

   always_ff @(posedge iCE_CLK or negedge reset_n) begin
      if (!reset_n) begin
         r_acc         <= '0;
         r_sum         <= '0;
         r_carry       <= 1'b0;
         r_out_valid   <= 1'b0;
         r_carry_latch <= 1'b0;
         r_ovf_latch   <= 1'b0;
      end else if (clear) begin
         r_acc         <= '0;
         r_sum         <= '0;
         r_carry       <= 1'b0;
         r_out_valid   <= 1'b0;
         r_carry_latch <= 1'b0;
         r_ovf_latch   <= 1'b0;
      end else if (w_accept) begin
         // Accumulator follows every accepted result, consumed or not.
         r_acc         <= w_res;
         r_sum         <= w_res;
         r_carry       <= w_cy;
         r_out_valid   <= 1'b1;
         r_carry_latch <= r_carry_latch | w_cy;
         r_ovf_latch   <= r_ovf_latch | w_ovf;
      end else if (out_ready) begin
         r_out_valid   <= 1'b0;
      end
   end

   assign out_valid      = r_out_valid;
   assign sum            = r_sum;
   assign carry          = r_carry;
   assign carry_latch    = r_carry_latch;
   assign overflow_latch = r_ovf_latch;

endmodule

// File: tb/tb_accum_adder.sv
// Purpose : randomized + directed bench for accum_adder, wrap (dut0) and saturating (dut1) builds side by side.
// Latency : expects results one cycle after each accept.
// Backpr. : drives out_ready low to stall and checks the held result and in_ready.
module tb_accum_adder;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       clr;
   logic       iv;
   logic [7:0] a;
   logic [7:0] b;
   logic [1:0] md;
   logic       ordy;

   logic       rdy0, ov0, cy0, cl0, ol0;
   logic [7:0] sum0;
   logic       rdy1, ov1, cy1, cl1, ol1;
   logic [7:0] sum1;

   int n_chk = 0;
   int n_err = 0;

   // Reference state, index 0 = wrap build, 1 = saturating build.
   logic [7:0] m_acc [2];
   logic [7:0] m_sum [2];
   bit         m_cy  [2];
   bit         m_cl  [2];
   bit         m_ol  [2];
   bit         m_valid;

   always #5 clk = ~clk;

   accum_adder #(.WIDTH(8), .SATURATE(1'b0)) dut0 (
      .iCE_CLK(clk), .reset_n(rst_n), .clear(clr), .in_valid(iv), .in_ready(rdy0),
      .in_a(a), .in_b(b), .mode(md), .out_valid(ov0), .out_ready(ordy),
      .sum(sum0), .carry(cy0), .carry_latch(cl0), .overflow_latch(ol0));

   accum_adder #(.WIDTH(8), .SATURATE(1'b1)) dut1 (
      .iCE_CLK(clk), .reset_n(rst_n), .clear(clr), .in_valid(iv), .in_ready(rdy1),
      .in_a(a), .in_b(b), .mode(md), .out_valid(ov1), .out_ready(ordy),
      .sum(sum1), .carry(cy1), .carry_latch(cl1), .overflow_latch(ol1));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Plain integer arithmetic: unsigned range for carry/borrow, signed range for overflow.
   function automatic void ref_op(input logic [7:0] acc, input logic [7:0] ia, input logic [7:0] ib,
                                  input logic [1:0] im, input bit sat,
                                  output logic [7:0] res, output bit cy, output bit ov);
      int x, y, r, sx, sy, sr;
      x  = im[1] ? int'(acc) : int'(ia);
      y  = im[1] ? int'(ia)  : int'(ib);
      sx = (x >= 128) ? x - 256 : x;
      sy = (y >= 128) ? y - 256 : y;
      if (!im[0]) begin
         r  = x + y;
         cy = (r > 255);
         sr = sx + sy;
      end else begin
         r  = x - y;
         cy = (x < y);
         sr = sx - sy;
      end
      ov  = (sr > 127) || (sr < -128);
      res = r[7:0];
      if (sat && cy) res = im[0] ? 8'h00 : 8'hFF;
   endfunction

   task automatic model_reset();
      for (int s = 0; s < 2; s++) begin
         m_acc[s] = 8'h00; m_sum[s] = 8'h00; m_cy[s] = 1'b0; m_cl[s] = 1'b0; m_ol[s] = 1'b0;
      end
      m_valid = 1'b0;
   endtask

   task automatic check_outputs();
      chk("out_valid0", ov0, m_valid);       chk("out_valid1", ov1, m_valid);
      chk("sum0", sum0, m_sum[0]);           chk("sum1", sum1, m_sum[1]);
      chk("carry0", cy0, m_cy[0]);           chk("carry1", cy1, m_cy[1]);
      chk("carry_latch0", cl0, m_cl[0]);     chk("carry_latch1", cl1, m_cl[1]);
      chk("ovf_latch0", ol0, m_ol[0]);       chk("ovf_latch1", ol1, m_ol[1]);
   endtask

   // Drive one cycle of inputs away from the edge, predict, clock, then compare.
   task automatic step(input bit v, input logic [7:0] ia, input logic [7:0] ib, input logic [1:0] im,
                       input bit ordy_i, input bit clr_i);
      bit         exp_rdy;
      logic [7:0] res;
      bit         cy, ov;
      iv = v; a = ia; b = ib; md = im; ordy = ordy_i; clr = clr_i;
      #1;
      exp_rdy = !clr_i && (!m_valid || ordy_i);
      chk("in_ready0", rdy0, exp_rdy);
      chk("in_ready1", rdy1, exp_rdy);
      if (clr_i) begin
         model_reset();
      end else if (v && exp_rdy) begin
         for (int s = 0; s < 2; s++) begin
            ref_op(m_acc[s], ia, ib, im, (s == 1), res, cy, ov);
            m_acc[s] = res; m_sum[s] = res; m_cy[s] = cy;
            m_cl[s]  = m_cl[s] | cy;
            m_ol[s]  = m_ol[s] | ov;
         end
         m_valid = 1'b1;
      end else if (ordy_i) begin
         m_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      check_outputs();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      model_reset();
      chk("rst_in_ready", {rdy1, rdy0}, 2'b00);
      chk("rst_out_valid", {ov1, ov0}, 2'b00);
      chk("rst_sum", {sum1, sum0}, 16'h0000);
      chk("rst_flags", {cy1, cl1, ol1, cy0, cl0, ol0}, 6'b0);
      @(posedge clk);
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      #1;
      chk("rel_in_ready", {rdy1, rdy0}, 2'b11);
      chk("rel_out_valid", {ov1, ov0}, 2'b00);
   endtask

   initial begin
      logic [7:0] acc_exp [4];
      rst_n = 1'b0; clr = 1'b0; iv = 1'b0; a = 8'h00; b = 8'h00; md = 2'b00; ordy = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;
      #1;
      check_outputs();

      // Add / subtract with wrap and saturation.
      step(1'b1, 8'hC8, 8'h64, 2'b00, 1'b1, 1'b0);
      chk("t2_add_sum0", sum0, 8'h2C);  chk("t2_add_sum1", sum1, 8'hFF);
      chk("t2_add_cy", {cy1, cy0}, 2'b11);
      chk("t2_add_latch0", {cl0, ol0}, 2'b10);
      step(1'b1, 8'h10, 8'h20, 2'b01, 1'b1, 1'b0);
      chk("t2_sub_sum0", sum0, 8'hF0);  chk("t2_sub_sum1", sum1, 8'h00);
      chk("t2_sub_cy", {cy1, cy0}, 2'b11);

      // Accumulate chain from a cleared accumulator.
      step(1'b0, 8'h00, 8'h00, 2'b00, 1'b1, 1'b1);
      acc_exp[0] = 8'h50; acc_exp[1] = 8'hA0; acc_exp[2] = 8'hF0; acc_exp[3] = 8'h40;
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 8'h50, 8'h00, 2'b10, 1'b1, 1'b0);
         chk("t3_acc_sum0", sum0, acc_exp[i]);
         chk("t3_acc_cy0", cy0, (i == 3));
         chk("t3_ovf_latch0", ol0, (i >= 1));
      end
      step(1'b1, 8'h50, 8'h00, 2'b11, 1'b1, 1'b0);
      chk("t3_accsub_sum0", sum0, 8'hF0);
      chk("t3_accsub_cy0", cy0, 1'b1);

      // Backpressure: second op must wait for the consumer.
      step(1'b1, 8'h11, 8'h22, 2'b00, 1'b1, 1'b0);
      step(1'b1, 8'h33, 8'h44, 2'b00, 1'b0, 1'b0);
      chk("t4_first", sum0, 8'h33);
      step(1'b1, 8'h55, 8'h66, 2'b00, 1'b0, 1'b0);
      chk("t4_held", sum0, 8'h33);
      chk("t4_held_valid", ov0, 1'b1);
      step(1'b1, 8'h55, 8'h66, 2'b00, 1'b1, 1'b0);
      chk("t4_second", sum0, 8'hBB);
      step(1'b0, 8'h00, 8'h00, 2'b00, 1'b1, 1'b0);
      chk("t4_drained", ov0, 1'b0);

      // clear colliding with a valid request.
      step(1'b1, 8'h01, 8'h01, 2'b00, 1'b0, 1'b0);
      chk("t5_pre", {ov0, cl0, ol0}, 3'b111);
      step(1'b1, 8'h01, 8'h01, 2'b00, 1'b0, 1'b1);
      chk("t5_cleared", {ov0, cl0, ol0, sum0}, 11'h000);
      step(1'b1, 8'h01, 8'h00, 2'b10, 1'b1, 1'b0);
      chk("t5_acc_zero", sum0, 8'h01);

      // Reset with a result pending.
      step(1'b1, 8'hFF, 8'h01, 2'b00, 1'b0, 1'b0);
      do_reset();
      step(1'b1, 8'h05, 8'h00, 2'b10, 1'b1, 1'b0);
      chk("t1_acc_after_rst", sum0, 8'h05);

      // Random traffic against the model.
      for (int i = 0; i < 600; i++) begin
         if (i == 300) do_reset();
         step($urandom_range(0, 3) != 0, 8'($urandom), 8'($urandom), 2'($urandom),
              $urandom_range(0, 3) != 0, $urandom_range(0, 30) == 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
